// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame geometry and the
// framing state machine encoding.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_rx_state_t;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 pin front end: synchronises both pins, glitch-filters the clock and
// emits a one-cycle pulse on each filtered falling edge.
// Ports:
//   clk, clrn   - system clock, async active-low reset
//   ps2_clk     - raw PS/2 clock pin (asynchronous)
//   ps2_data    - raw PS/2 data pin (asynchronous)
//   fall        - one-cycle pulse on a filtered clock 1->0 transition
//   sdata       - synchronised data bit, to be sampled while fall=1
module ps2_clk_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic sdata
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] csync_q, csync_d;
  logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   fclk_q, fclk_d;
  logic                   fclk_dly_q, fclk_dly_d;
  logic                   fall_q, fall_d;
  logic                   csync_out;

  assign csync_out = csync_q[SYNC_STAGES-1];

  // Synchroniser shift, glitch filter and edge detect.
  always_comb begin
    csync_d    = {csync_q[SYNC_STAGES-2:0], ps2_clk};
    dsync_d    = {dsync_q[SYNC_STAGES-2:0], ps2_data};
    cnt_d      = '0;
    fclk_d     = fclk_q;
    fclk_dly_d = fclk_q;
    // Count consecutive samples that disagree with fclk; any agreeing
    // sample restarts the count, so short pulses never propagate.
    if (csync_out != fclk_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        fclk_d = csync_out;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    fall_d = fclk_dly_q & ~fclk_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      csync_q    <= '1;
      dsync_q    <= '1;
      cnt_q      <= '0;
      fclk_q     <= 1'b1;
      fclk_dly_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      csync_q    <= csync_d;
      dsync_q    <= dsync_d;
      cnt_q      <= cnt_d;
      fclk_q     <= fclk_d;
      fclk_dly_q <= fclk_dly_d;
      fall_q     <= fall_d;
    end
  end

  assign fall  = fall_q;
  assign sdata = dsync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: frames 11-bit PS/2 words, checks start,
// stop and odd parity, guards against stalled frames with a timeout, and
// queues good scan codes in a drop-on-full FIFO.
// Ports:
//   clk, clrn    - system clock, async active-low reset
//   ps2_clk/data - raw PS/2 pins
//   nextdata_n   - active-low pop request
//   clr_err      - clears the sticky error flags
//   data, ready  - FIFO head and non-empty indication
//   level        - FIFO fill level
//   overflow, parity_err, frame_err, timeout_err - sticky error flags
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  input  logic                       nextdata_n,
  input  logic                       clr_err,
  output logic [7:0]                 data,
  output logic                       ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       timeout_err
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BI_W  = $clog2(PS2_FRAME_BITS);

  logic fall;
  logic sdata;

  ps2_clk_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .sdata    (sdata)
  );

  ps2_rx_state_t state_q, state_d;
  logic [BI_W-1:0]  bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             overflow_q, overflow_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout_err_q, timeout_err_d;

  logic frame_ok_c, set_frame_c, set_parity_c, set_timeout_c, set_overflow_c;
  logic push_c, pop_c, full_c, par_good_c;

  // Framing FSM and inter-edge timeout.
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    par_d         = par_q;
    frame_ok_c    = 1'b0;
    set_frame_c   = 1'b0;
    set_parity_c  = 1'b0;
    set_timeout_c = 1'b0;
    par_good_c    = ^{shreg_q, par_q};

    if ((state_q == ST_IDLE) || fall) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          if (!sdata) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            set_frame_c = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (fall) begin
          // LSB arrives first: shift in from the top.
          shreg_d = {sdata, shreg_q[7:1]};
          if (bit_idx_q == BI_W'(PS2_DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + BI_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = sdata;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d      = ST_IDLE;
          set_frame_c  = ~sdata;
          set_parity_c = ~par_good_c;
          frame_ok_c   = sdata & par_good_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter would reach TIMEOUT_CYC this cycle: abandon the partial frame.
    if ((state_q != ST_IDLE) && !fall && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1))) begin
      state_d       = ST_IDLE;
      to_cnt_d      = '0;
      set_timeout_c = 1'b1;
    end
  end

  // FIFO with drop-on-full; a same-cycle pop frees a slot for the push.
  always_comb begin
    pop_c          = ~nextdata_n & (level_q != '0);
    full_c         = (level_q == LVL_W'(DEPTH));
    push_c         = frame_ok_c & (~full_c | pop_c);
    set_overflow_c = frame_ok_c & ~push_c;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push_c) begin
      mem_d[wr_ptr_q] = shreg_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    data_d  = mem_d[rd_ptr_d];
    ready_d = (level_d != '0);

    // Sticky flags: a new set condition beats a simultaneous clear.
    overflow_d    = (overflow_q    & ~clr_err) | set_overflow_c;
    parity_err_d  = (parity_err_q  & ~clr_err) | set_parity_c;
    frame_err_d   = (frame_err_q   & ~clr_err) | set_frame_c;
    timeout_err_d = (timeout_err_q & ~clr_err) | set_timeout_c;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= ST_IDLE;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      par_q         <= 1'b0;
      to_cnt_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      data_q        <= '0;
      ready_q       <= 1'b0;
      overflow_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      par_q         <= par_d;
      to_cnt_q      <= to_cnt_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      data_q        <= data_d;
      ready_q       <= ready_d;
      overflow_q    <= overflow_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign data        = data_q;
  assign ready       = ready_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames on the pins and checks
// FIFO contents, fill level and sticky flags against hand-computed values.
module tb_ps2_rx_fifo;

  localparam int H   = 12;   // PS/2 half period in clk cycles
  localparam int TO  = 64;   // timeout used for this bench
  localparam int LAT = 7;    // pin-to-fall latency: SYNC_STAGES + FILTER_LEN + 1

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic       clr_err;
  logic [7:0] data;
  logic       ready;
  logic [3:0] level;
  logic       overflow, parity_err, frame_err, timeout_err;

  int total = 0;
  int bad   = 0;

  ps2_rx_fifo #(
    .DEPTH       (8),
    .SYNC_STAGES (2),
    .FILTER_LEN  (4),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .nextdata_n  (nextdata_n),
    .clr_err     (clr_err),
    .data        (data),
    .ready       (ready),
    .level       (level),
    .overflow    (overflow),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set while clock high, then a low phase.
  task automatic send_bit(input logic b, input bit glitch, input bit pop_at_fall);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(4);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(H - 7);
    end else begin
      wait_cyc(H);
    end
    ps2_clk = 1'b0;
    if (pop_at_fall) begin
      wait_cyc(LAT);
      nextdata_n = 1'b0;
      wait_cyc(1);
      nextdata_n = 1'b1;
      wait_cyc(H - LAT - 1);
    end else begin
      wait_cyc(H);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int glitch_bit, input bit pop_stop);
    send_bit(1'b0, glitch_bit == 0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i + 1, 1'b0);
    send_bit(par, glitch_bit == 9, 1'b0);
    send_bit(stop, 1'b0, pop_stop);
    ps2_data = 1'b1;
    wait_cyc(4);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1, -1, 1'b0);
  endtask

  task automatic pop_one();
    nextdata_n = 1'b0;
    wait_cyc(1);
    nextdata_n = 1'b1;
    wait_cyc(1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    wait_cyc(1);
  endtask

  task automatic test_reset();
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1; clr_err = 1'b0;
    wait_cyc(3);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
    total++; if ({overflow, parity_err, frame_err, timeout_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {overflow, parity_err, frame_err, timeout_err}); end
    clrn = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b0);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", ready); end
    total++; if (data !== 8'h1C) begin bad++; $display("FAIL single_data got=%h exp=1c", data); end
    total++; if (level !== 4'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
    total++; if ({overflow, parity_err, frame_err, timeout_err} !== 4'b0000) begin
      bad++; $display("FAIL single_flags got=%b exp=0000", {overflow, parity_err, frame_err, timeout_err}); end
    pop_one();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_pop_ready got=%b exp=0", ready); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL single_pop_level got=%0d exp=0", level); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 9; i++) send_good(8'(i));
    total++; if (level !== 4'd8) begin bad++; $display("FAIL full_level got=%0d exp=8", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%b exp=1", overflow); end
    for (int i = 1; i <= 8; i++) begin
      total++; if (data !== 8'(i)) begin bad++; $display("FAIL full_read%0d got=%h exp=%h", i, data, 8'(i)); end
      pop_one();
    end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL full_drained_ready got=%b exp=0", ready); end
    pulse_clr();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_clr_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_frame_errors();
    send_frame(8'hF0, 1'b0, 1'b1, -1, 1'b0);
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL perr_flag got=%b exp=1", parity_err); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL perr_frame got=%b exp=0", frame_err); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL perr_level got=%0d exp=0", level); end
    pulse_clr();
    send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL ferr_parity got=%b exp=0", parity_err); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL ferr_level got=%0d exp=0", level); end
    pulse_clr();
  endtask

  task automatic test_glitch();
    send_frame(8'h29, 1'b0, 1'b1, 4, 1'b0);
    total++; if (data !== 8'h29) begin bad++; $display("FAIL glitch_data got=%h exp=29", data); end
    total++; if (level !== 4'd1) begin bad++; $display("FAIL glitch_level got=%0d exp=1", level); end
    total++; if ({overflow, parity_err, frame_err, timeout_err} !== 4'b0000) begin
      bad++; $display("FAIL glitch_flags got=%b exp=0000", {overflow, parity_err, frame_err, timeout_err}); end
    pop_one();
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    b = 8'h5A;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(TO + 40);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", timeout_err); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL to_frame got=%b exp=0", frame_err); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL to_level got=%0d exp=0", level); end
    pulse_clr();
    send_frame(8'h5A, 1'b1, 1'b1, -1, 1'b0);
    total++; if (data !== 8'h5A) begin bad++; $display("FAIL to_next_data got=%h exp=5a", data); end
    total++; if (level !== 4'd1) begin bad++; $display("FAIL to_next_level got=%0d exp=1", level); end
    total++; if ({overflow, parity_err, frame_err, timeout_err} !== 4'b0000) begin
      bad++; $display("FAIL to_next_flags got=%b exp=0000", {overflow, parity_err, frame_err, timeout_err}); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) send_good(8'h10 + 8'(i));
    total++; if (level !== 4'd8) begin bad++; $display("FAIL b2b_fill got=%0d exp=8", level); end
    // 0x18 has two ones, so the odd-parity bit is 1.
    send_frame(8'h18, 1'b1, 1'b1, -1, 1'b1);
    total++; if (level !== 4'd8) begin bad++; $display("FAIL b2b_level got=%0d exp=8", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
    for (int i = 1; i <= 8; i++) begin
      total++; if (data !== 8'h10 + 8'(i)) begin
        bad++; $display("FAIL b2b_read%0d got=%h exp=%h", i, data, 8'h10 + 8'(i)); end
      pop_one();
    end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", ready); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    send_good(8'h33);
    send_bit(1'b1, 1'b0, 1'b0);   // bad start bit
    wait_cyc(H);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL badstart_flag got=%b exp=1", frame_err); end
    b = 8'h44;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i], 1'b0, 1'b0);
    wait_cyc(2);
    #3 clrn = 1'b0;
    #1;
    total++; if ({ready, level, data} !== 13'd0) begin
      bad++; $display("FAIL midrst_outputs got=%b/%0d/%h exp=0/0/00", ready, level, data); end
    total++; if ({overflow, parity_err, frame_err, timeout_err} !== 4'b0000) begin
      bad++; $display("FAIL midrst_flags got=%b exp=0000", {overflow, parity_err, frame_err, timeout_err}); end
    ps2_data = 1'b1;
    @(negedge clk);
    clrn = 1'b1;
    wait_cyc(5);
    send_frame(8'h6B, 1'b0, 1'b1, -1, 1'b0);
    total++; if (data !== 8'h6B) begin bad++; $display("FAIL midrst_data got=%h exp=6b", data); end
    total++; if (level !== 4'd1) begin bad++; $display("FAIL midrst_level got=%0d exp=1", level); end
    total++; if ({overflow, parity_err, frame_err, timeout_err} !== 4'b0000) begin
      bad++; $display("FAIL midrst_after_flags got=%b exp=0000", {overflow, parity_err, frame_err, timeout_err}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_frame_errors();
    test_glitch();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with a scan-code FIFO. It replaces the fixed 8-entry keyboard receiver in the PS/2 input path. New features over that receiver: glitch filtering of `ps2_clk`, a framing state machine with inter-bit timeout, sticky per-cause error flags, a FIFO fill level, and drop-on-full behaviour instead of overwrite. It sits between the PS/2 pins and the scan-code consumer (keyboard decoder / display logic), all in the `clk` domain.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `SYNC_STAGES`, 2, synchroniser flops on `ps2_clk` and `ps2_data` (≥2)
- `FILTER_LEN`, 4, consecutive equal synchronised samples needed before the filtered clock changes (≥1)
- `TIMEOUT_CYC`, 100000, `clk` cycles allowed between falling edges inside a frame
- `clk`  in  1  system clock; single clock domain
- `clrn`  in  1  reset, asynchronous, active-low
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous
- `nextdata_n`  in  1  active-low pop request
- `clr_err`  in  1  synchronous pulse that clears all sticky flags
- `data`  out  8  FIFO head; valid only while `ready`=1
- `ready`  out  1  FIFO non-empty
- `level`  out  $clog2(DEPTH)+1  number of stored entries
- `overflow`  out  1  sticky; set when a valid frame is dropped because the FIFO is full
- `parity_err`  out  1  sticky; set when a frame fails the odd-parity check
- `frame_err`  out  1  sticky; set on a bad start bit or bad stop bit
- `timeout_err`  out  1  sticky; set when the inter-edge timeout fires mid-frame

## Operation
- **Front end**
  - `ps2_clk` and `ps2_data` each pass through `SYNC_STAGES` flops.
  - Filtered clock `fclk` takes the synchronised value only after `FILTER_LEN` identical consecutive samples.
  - `fall` is a 1-cycle pulse on an `fclk` 1→0 transition.
  - The data bit used is the synchronised `ps2_data` in the `fall` cycle.
- **Framing FSM** (states IDLE, DATA, PARITY, STOP)
  - IDLE: on `fall` with data=0, go to DATA, bit index 0. On `fall` with data=1, set `frame_err` and stay in IDLE.
  - DATA: on each `fall`, shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on `fall`, go to IDLE. The frame is valid iff stop=1 and XOR(8 data bits, parity)=1.
    - stop=0: set `frame_err`.
    - Odd-parity fail: set `parity_err`.
    - Both fail: set both flags.
    - Invalid frames are never pushed.
- **Timeout**
  - Counter clears on every `fall` and in IDLE. It increments in any other state.
  - On reaching `TIMEOUT_CYC`: go to IDLE, set `timeout_err`, discard the partial frame.
- **FIFO**
  - Push on a valid frame if `level`<DEPTH, or if `level`=DEPTH with an accepted pop in the same cycle.
  - Otherwise drop the byte and set `overflow`; existing entries are untouched.
  - A pop is accepted when `nextdata_n`=0 and `ready`=1. Pop while empty is ignored.
  - Pointers wrap modulo DEPTH.
  - `level` is +1 for push only, −1 for pop only, and unchanged when push and pop happen together.
  - `ready` = (`level`≠0). `data` = entry at the read pointer.
- **Sticky flags**: `clr_err`=1 clears all four flags. A set condition in the same cycle wins over the clear.

## Timing
- Reset (`clrn`=0, takes effect immediately, asynchronously):
  - `ready`=0, `level`=0, `data`=0, all four flags 0.
  - Pointers 0, FSM in IDLE, timeout counter 0.
  - Synchroniser and filter registers preset to 1 (bus idle).
- Reset asserted mid-frame aborts the frame. After release, the receiver waits for a fresh start bit.
- Pin-to-`fall` latency: `SYNC_STAGES`+`FILTER_LEN`+1 `clk` cycles after a stable pin edge.
- Push commits at the clock edge ending the STOP `fall` cycle. `ready`, `level` and `data` reflect it from the next cycle.
- Pop: `nextdata_n` is sampled at a rising `clk` edge. `data`/`level` update in the following cycle. Holding `nextdata_n` low pops one entry per cycle while non-empty.
- Error flags assert in the cycle after the offending `fall` or timeout.

## Structure
- Package `ps2_pkg`:
  - FSM state enum `ps2_rx_state_t`.
  - Constants `PS2_DATA_BITS`=8 and `PS2_FRAME_BITS`=11.
- Sub-module `ps2_clk_filter`: synchroniser + glitch filter + falling-edge pulse. Outputs `fall` and the synchronised data bit.
- The FSM, timeout counter and FIFO live in `ps2_rx_fifo`.

## Test plan
- **Single frame.** Frame 0x1C with parity bit 0 (odd total)
  - → `ready`=1, `data`=0x1C, `level`=1, no flags.
  - One-cycle `nextdata_n`=0 → `ready`=0, `level`=0.
- **Full FIFO.** DEPTH=8; send 0x01…0x09 with no reads
  - → `level`=8, `overflow`=1.
  - Reads return 0x01…0x08; 0x09 is absent.
  - `clr_err` → `overflow`=0.
- **Frame errors.**
  - 0xF0 with parity bit 0 → `parity_err`=1, `level` unchanged.
  - 0x5A with stop bit 0 → `frame_err`=1, not pushed.
- **Glitch rejection.** `ps2_clk` low pulse of `FILTER_LEN`−1 cycles inside a frame → no extra bit sampled; frame 0x29 is received correctly.
- **Timeout.**
  - Stop clocking after 5 bits; wait `TIMEOUT_CYC` cycles → `timeout_err`=1, FSM in IDLE.
  - A following frame 0x5A is received intact.
- **Boundaries.**
  - FIFO full, valid frame and pop in the same cycle → push accepted, `level` stays 8, `overflow`=0.
  - `clrn` pulsed low mid-frame → all outputs 0 immediately; the next full frame is received correctly.
